// File: rtl/can_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : can_rx_framer
//  Purpose  : Receive-side bit destuffer and CAN 2.0A (standard format) frame
//             decoder. Consumes the sampled bus level one bit per baud_clk
//             strobe, strips stuff bits, walks the frame fields, checks the
//             CRC-15 and publishes ID/DLC/RTR/data with a one-cycle valid
//             pulse. Extended-format frames are rejected as form errors.
//  Ports    :
//    clk       in   system clock, rising-edge active
//    rst       in   asynchronous active-high reset
//    baud_clk  in   one-cycle bit-sample strobe; rx is consumed only when high
//    rx        in   bus level (0 = dominant, 1 = recessive)
//    rx_data   out  data bytes, byte 0 in [63:56], unused bytes zero
//    rx_id     out  11-bit identifier of the last valid frame
//    rx_dlc    out  DLC exactly as received
//    rx_rtr    out  RTR bit of the last valid frame
//    rx_valid  out  one-cycle pulse, frame outputs just updated
//    rx_err    out  one-cycle pulse, frame aborted
//    err_code  out  01 stuff, 10 CRC, 11 form; held until the next rx_err
//    rxing     out  high from SOF through the CRC delimiter
//  Revision : 1.0  initial release
// ============================================================================
module can_rx_framer #(
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_clk,
  input  logic        rx,
  output logic [63:0] rx_data,
  output logic [10:0] rx_id,
  output logic [3:0]  rx_dlc,
  output logic        rx_rtr,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  err_code,
  output logic        rxing
);

  localparam int          ICW       = $clog2(IDLE_BITS + 1);
  localparam logic [14:0] CRC_POLY  = 15'h4599;
  localparam logic [1:0]  ERR_STUFF = 2'b01;
  localparam logic [1:0]  ERR_CRC   = 2'b10;
  localparam logic [1:0]  ERR_FORM  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ID        = 4'd1,
    S_RTR       = 4'd2,
    S_IDE       = 4'd3,
    S_R0        = 4'd4,
    S_DLC       = 4'd5,
    S_DATA      = 4'd6,
    S_CRC       = 4'd7,
    S_CRC_DEL   = 4'd8,
    S_WAIT_IDLE = 4'd9
  } state_t;

  state_t         state, state_nxt;
  logic [5:0]     bit_cnt, bit_cnt_nxt;
  logic [2:0]     run_cnt, run_cnt_nxt;
  logic           run_val, run_val_nxt;
  logic [14:0]    crc, crc_nxt;
  logic [14:0]    crc_rx, crc_rx_nxt;
  logic [10:0]    id_sh, id_sh_nxt;
  logic           rtr_sh, rtr_sh_nxt;
  logic [3:0]     dlc_sh, dlc_sh_nxt;
  logic [5:0]     data_last, data_last_nxt;
  logic [63:0]    data_sh, data_sh_nxt;
  logic [ICW-1:0] idle_cnt, idle_cnt_nxt;

  logic [63:0]    rx_data_nxt;
  logic [10:0]    rx_id_nxt;
  logic [3:0]     rx_dlc_nxt;
  logic           rx_rtr_nxt;
  logic           rx_valid_nxt;
  logic           rx_err_nxt;
  logic [1:0]     err_code_nxt;
  logic           rxing_nxt;

  logic           in_zone;
  logic           stuff_slot;
  logic [3:0]     dlc_full;
  logic [3:0]     byte_cnt;
  logic           fault;
  logic [1:0]     fault_code;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC_POLY : 15'h0000);
  endfunction

  // Stuffing covers SOF through the last CRC bit; SOF itself seeds the run.
  assign in_zone    = (state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC});
  assign stuff_slot = in_zone && (run_cnt == 3'd5);

  // DLC including the bit being sampled now, so the field length is known
  // on the same edge that consumes the last DLC bit.
  assign dlc_full = {dlc_sh[2:0], rx};
  assign byte_cnt = rtr_sh ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    run_cnt_nxt   = run_cnt;
    run_val_nxt   = run_val;
    crc_nxt       = crc;
    crc_rx_nxt    = crc_rx;
    id_sh_nxt     = id_sh;
    rtr_sh_nxt    = rtr_sh;
    dlc_sh_nxt    = dlc_sh;
    data_last_nxt = data_last;
    data_sh_nxt   = data_sh;
    idle_cnt_nxt  = idle_cnt;
    rx_data_nxt   = rx_data;
    rx_id_nxt     = rx_id;
    rx_dlc_nxt    = rx_dlc;
    rx_rtr_nxt    = rx_rtr;
    rx_valid_nxt  = 1'b0;
    rx_err_nxt    = 1'b0;
    err_code_nxt  = err_code;
    rxing_nxt     = rxing;
    fault         = 1'b0;
    fault_code    = ERR_FORM;

    if (baud_clk) begin
      if (stuff_slot) begin
        // Stuff bit: discard it and restart the run, field counters frozen.
        // A stuff error preempts whatever field the bit would have ended.
        if (rx == run_val) begin
          fault      = 1'b1;
          fault_code = ERR_STUFF;
        end else begin
          run_cnt_nxt = 3'd1;
          run_val_nxt = rx;
        end
      end else begin
        if (in_zone) begin
          if (rx == run_val) begin
            run_cnt_nxt = run_cnt + 3'd1;
          end else begin
            run_cnt_nxt = 3'd1;
            run_val_nxt = rx;
          end
        end

        case (state)
          S_IDLE: begin
            if (!rx) begin
              state_nxt   = S_ID;
              bit_cnt_nxt = 6'd0;
              run_cnt_nxt = 3'd1;
              run_val_nxt = 1'b0;
              crc_nxt     = crc_step(15'h0000, rx);
              data_sh_nxt = 64'h0;
              rxing_nxt   = 1'b1;
            end
          end

          S_ID: begin
            crc_nxt   = crc_step(crc, rx);
            id_sh_nxt = {id_sh[9:0], rx};
            if (bit_cnt == 6'd10) begin
              state_nxt   = S_RTR;
              bit_cnt_nxt = 6'd0;
            end else begin
              bit_cnt_nxt = bit_cnt + 6'd1;
            end
          end

          S_RTR: begin
            crc_nxt    = crc_step(crc, rx);
            rtr_sh_nxt = rx;
            state_nxt  = S_IDE;
          end

          S_IDE: begin
            crc_nxt = crc_step(crc, rx);
            if (rx) begin
              fault      = 1'b1;
              fault_code = ERR_FORM;
            end else begin
              state_nxt = S_R0;
            end
          end

          S_R0: begin
            crc_nxt     = crc_step(crc, rx);
            state_nxt   = S_DLC;
            bit_cnt_nxt = 6'd0;
          end

          S_DLC: begin
            crc_nxt    = crc_step(crc, rx);
            dlc_sh_nxt = dlc_full;
            if (bit_cnt == 6'd3) begin
              bit_cnt_nxt = 6'd0;
              // 8 bytes wraps to 0 in the low bits, giving 63 after the -1.
              data_last_nxt = {byte_cnt[2:0], 3'b000} - 6'd1;
              state_nxt     = (byte_cnt == 4'd0) ? S_CRC : S_DATA;
            end else begin
              bit_cnt_nxt = bit_cnt + 6'd1;
            end
          end

          S_DATA: begin
            crc_nxt                      = crc_step(crc, rx);
            data_sh_nxt[6'd63 - bit_cnt] = rx;
            if (bit_cnt == data_last) begin
              state_nxt   = S_CRC;
              bit_cnt_nxt = 6'd0;
            end else begin
              bit_cnt_nxt = bit_cnt + 6'd1;
            end
          end

          S_CRC: begin
            crc_rx_nxt = {crc_rx[13:0], rx};
            if (bit_cnt == 6'd14) begin
              state_nxt   = S_CRC_DEL;
              bit_cnt_nxt = 6'd0;
            end else begin
              bit_cnt_nxt = bit_cnt + 6'd1;
            end
          end

          S_CRC_DEL: begin
            rxing_nxt = 1'b0;
            if (!rx) begin
              fault      = 1'b1;
              fault_code = ERR_FORM;
            end else if (crc_rx != crc) begin
              fault      = 1'b1;
              fault_code = ERR_CRC;
            end else begin
              rx_id_nxt    = id_sh;
              rx_dlc_nxt   = dlc_sh;
              rx_rtr_nxt   = rtr_sh;
              rx_data_nxt  = data_sh;
              rx_valid_nxt = 1'b1;
              state_nxt    = S_IDLE;
            end
          end

          S_WAIT_IDLE: begin
            if (rx) begin
              if (idle_cnt == ICW'(IDLE_BITS - 1)) begin
                idle_cnt_nxt = '0;
                state_nxt    = S_IDLE;
              end else begin
                idle_cnt_nxt = idle_cnt + ICW'(1);
              end
            end else begin
              idle_cnt_nxt = '0;
            end
          end

          default: state_nxt = S_IDLE;
        endcase
      end

      if (fault) begin
        state_nxt    = S_WAIT_IDLE;
        idle_cnt_nxt = '0;
        rx_err_nxt   = 1'b1;
        err_code_nxt = fault_code;
        rxing_nxt    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 6'd0;
      run_cnt   <= 3'd0;
      run_val   <= 1'b0;
      crc       <= 15'h0000;
      crc_rx    <= 15'h0000;
      id_sh     <= 11'h000;
      rtr_sh    <= 1'b0;
      dlc_sh    <= 4'h0;
      data_last <= 6'd0;
      data_sh   <= 64'h0;
      idle_cnt  <= '0;
      rx_data   <= 64'h0;
      rx_id     <= 11'h000;
      rx_dlc    <= 4'h0;
      rx_rtr    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      err_code  <= 2'b00;
      rxing     <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      run_cnt   <= run_cnt_nxt;
      run_val   <= run_val_nxt;
      crc       <= crc_nxt;
      crc_rx    <= crc_rx_nxt;
      id_sh     <= id_sh_nxt;
      rtr_sh    <= rtr_sh_nxt;
      dlc_sh    <= dlc_sh_nxt;
      data_last <= data_last_nxt;
      data_sh   <= data_sh_nxt;
      idle_cnt  <= idle_cnt_nxt;
      rx_data   <= rx_data_nxt;
      rx_id     <= rx_id_nxt;
      rx_dlc    <= rx_dlc_nxt;
      rx_rtr    <= rx_rtr_nxt;
      rx_valid  <= rx_valid_nxt;
      rx_err    <= rx_err_nxt;
      err_code  <= err_code_nxt;
      rxing     <= rxing_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_can_rx_framer
//  Purpose  : Self-checking bench for can_rx_framer. Frames are built from a
//             vector table (fields, corruption kind, expected result), stuffed
//             and serialised onto rx; expected pulses go into a scoreboard
//             queue and are compared when the DUT pulses rx_valid / rx_err.
//  Revision : 1.0  initial release
// ============================================================================
module tb_can_rx_framer;

  logic        clk;
  logic        rst;
  logic        baud_clk;
  logic        rx;
  logic [63:0] rx_data;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic        rx_rtr;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  err_code;
  logic        rxing;

  can_rx_framer #(.IDLE_BITS(11)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_clk (baud_clk),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_id    (rx_id),
    .rx_dlc   (rx_dlc),
    .rx_rtr   (rx_rtr),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_code (err_code),
    .rxing    (rxing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // corrupt: 0 none, 1 first CRC bit inverted, 2 dominant delimiter,
  //          3 first stuff bit omitted
  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic        ide;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          corrupt;
    bit          is_err;
    logic [1:0]  code;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic        rtr;
    logic [63:0] data;
  } exp_t;

  localparam int NV = 9;
  vec_t  tbl [NV];
  exp_t  sb [$];
  bit    raw [$];
  bit    tx [$];
  int    bdiv;
  int    errors;
  int    checks;

  logic [10:0] last_id;
  logic [3:0]  last_dlc;
  logic        last_rtr;
  logic [63:0] last_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_valid || rx_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none", rx_valid, rx_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", 64'({rx_valid, rx_err}), e.is_err ? 64'd1 : 64'd2);
        check("rxing_at_pulse", 64'(rxing), 64'd0);
        if (e.is_err) begin
          check("err_code", 64'(err_code), 64'(e.code));
          check("held_id", 64'(rx_id), 64'(last_id));
          check("held_dlc", 64'(rx_dlc), 64'(last_dlc));
          check("held_rtr", 64'(rx_rtr), 64'(last_rtr));
          check("held_data", rx_data, last_data);
        end else begin
          check("rx_id", 64'(rx_id), 64'(e.id));
          check("rx_dlc", 64'(rx_dlc), 64'(e.dlc));
          check("rx_rtr", 64'(rx_rtr), 64'(e.rtr));
          check("rx_data", rx_data, e.data);
          last_id   = e.id;
          last_dlc  = e.dlc;
          last_rtr  = e.rtr;
          last_data = e.data;
        end
      end
    end
  end

  task automatic tick(input bit b, input bit s);
    rx       = b;
    baud_clk = s;
    @(posedge clk);
    #1;
    baud_clk = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    for (int i = 1; i < bdiv; i++) tick(b, 1'b0);
    tick(b, 1'b1);
  endtask

  task automatic build(input vec_t v);
    logic [14:0] c;
    int nb;
    int run;
    bit last;
    bit dropped;
    raw.delete();
    tx.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(v.id[i]);
    raw.push_back(v.rtr);
    raw.push_back(v.ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(v.dlc[i]);
    nb = v.rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
    for (int i = 0; i < nb * 8; i++) raw.push_back(v.data[63 - i]);
    c = 15'h0;
    foreach (raw[i]) c = {c[13:0], 1'b0} ^ ((raw[i] ^ c[14]) ? 15'h4599 : 15'h0);
    if (v.corrupt == 1) c[14] = ~c[14];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    run = 0;
    last = 1'b0;
    dropped = 1'b0;
    foreach (raw[i]) begin
      tx.push_back(raw[i]);
      if (i != 0 && raw[i] == last) run++;
      else run = 1;
      last = raw[i];
      if (run == 5 && i != raw.size() - 1) begin
        if (v.corrupt == 3 && !dropped) dropped = 1'b1;
        else tx.push_back(~last);
        run  = 1;
        last = ~last;
      end
    end
  endtask

  task automatic send_vec(input vec_t v, input int idle, input bit push,
                          input bit exp_rxing, input int maxbits);
    exp_t e;
    build(v);
    if (push) begin
      e.is_err = v.is_err;
      e.code   = v.code;
      e.id     = v.id;
      e.dlc    = v.dlc;
      e.rtr    = v.rtr;
      e.data   = v.exp_data;
      sb.push_back(e);
    end
    foreach (tx[i]) begin
      if (maxbits > 0 && i >= maxbits) return;
      send_bit(tx[i]);
      if (i == 0) check("rxing_after_sof", 64'(rxing), 64'(exp_rxing));
    end
    send_bit(v.corrupt == 2 ? 1'b0 : 1'b1);
    for (int i = 0; i < idle; i++) send_bit(1'b1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    bdiv      = 4;
    last_id   = '0;
    last_dlc  = '0;
    last_rtr  = 1'b0;
    last_data = '0;
    rst       = 1'b1;
    baud_clk  = 1'b0;
    rx        = 1'b1;

    tbl[0] = '{11'h123, 1'b0, 1'b0, 4'd2,  64'hAA55_0000_0000_0000, 0, 1'b0, 2'b00, 64'hAA55_0000_0000_0000};
    tbl[1] = '{11'h000, 1'b0, 1'b0, 4'd0,  64'h0,                   0, 1'b0, 2'b00, 64'h0};
    tbl[2] = '{11'h000, 1'b0, 1'b0, 4'd0,  64'h0,                   3, 1'b1, 2'b01, 64'h0};
    tbl[3] = '{11'h123, 1'b0, 1'b0, 4'd2,  64'hAA55_0000_0000_0000, 1, 1'b1, 2'b10, 64'h0};
    tbl[4] = '{11'h7A1, 1'b0, 1'b0, 4'd12, 64'h0102_0304_0506_0708, 0, 1'b0, 2'b00, 64'h0102_0304_0506_0708};
    tbl[5] = '{11'h2A5, 1'b1, 1'b0, 4'd4,  64'hDEAD_BEEF_0000_0000, 0, 1'b0, 2'b00, 64'h0};
    tbl[6] = '{11'h555, 1'b0, 1'b1, 4'd1,  64'h3C00_0000_0000_0000, 0, 1'b1, 2'b11, 64'h0};
    tbl[7] = '{11'h0F0, 1'b0, 1'b0, 4'd1,  64'h8100_0000_0000_0000, 2, 1'b1, 2'b11, 64'h0};
    tbl[8] = '{11'h7FF, 1'b0, 1'b0, 4'd8,  64'hFF00_FF00_FF00_FF00, 0, 1'b0, 2'b00, 64'hFF00_FF00_FF00_FF00};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 64'h0);
    check("reset_rx_id", 64'(rx_id), 64'h0);
    check("reset_rx_dlc", 64'(rx_dlc), 64'h0);
    check("reset_rx_rtr", 64'(rx_rtr), 64'h0);
    check("reset_rx_valid", 64'(rx_valid), 64'h0);
    check("reset_rx_err", 64'(rx_err), 64'h0);
    check("reset_err_code", 64'(err_code), 64'h0);
    check("reset_rxing", 64'(rxing), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);

    // Whole table at three strobe rates: every 4th, every cycle, every 16th.
    for (int p = 0; p < 3; p++) begin
      bdiv = (p == 0) ? 4 : ((p == 1) ? 1 : 16);
      for (int k = 0; k < NV; k++) send_vec(tbl[k], 12, 1'b1, 1'b1, 0);
    end

    // Re-arm boundary: 10 recessive bits after a CRC error are not enough.
    bdiv = 4;
    send_vec(tbl[3], 10, 1'b1, 1'b1, 0);
    send_vec(tbl[0], 12, 1'b0, 1'b0, 0);
    send_vec(tbl[4], 12, 1'b1, 1'b1, 0);
    // Exactly 11 recessive bits re-arm the receiver.
    send_vec(tbl[3], 11, 1'b1, 1'b1, 0);
    send_vec(tbl[8], 12, 1'b1, 1'b1, 0);

    // Reset in the middle of the data field: no pulse, everything cleared.
    send_vec(tbl[0], 0, 1'b0, 1'b1, 28);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rx_data", rx_data, 64'h0);
    check("midrst_rx_id", 64'(rx_id), 64'h0);
    check("midrst_rx_dlc", 64'(rx_dlc), 64'h0);
    check("midrst_rx_rtr", 64'(rx_rtr), 64'h0);
    check("midrst_err_code", 64'(err_code), 64'h0);
    check("midrst_rxing", 64'(rxing), 64'h0);
    last_id   = '0;
    last_dlc  = '0;
    last_rtr  = 1'b0;
    last_data = '0;
    rx  = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_vec(tbl[0], 12, 1'b1, 1'b1, 0);

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/can_rx_framer.md
# can_rx_framer

Receive-side bit destuffer and CAN 2.0A frame decoder. Sits directly upstream of the receive data buffer and consumes the sampled serial `rx` line, one bit per `baud_clk` strobe. It removes stuff bits, tracks the standard-format frame fields, checks CRC-15, and presents ID, DLC and a 64-bit data word with a one-cycle valid pulse. Extended (IDE=1) frames are rejected as format errors.

## Interface
- `IDLE_BITS`, default 11: consecutive recessive bits required to re-arm after an error.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_clk`  in  1  bit-sample strobe, one `clk` cycle wide, synchronous to `clk`; `rx` is sampled only when high.
- `rx`  in  1  bus level, 0 = dominant, 1 = recessive.
- `rx_data`  out  64  data bytes; byte 0 in [63:56], MSB first; unused bytes 0.
- `rx_id`  out  11  identifier.
- `rx_dlc`  out  4  DLC exactly as received (0–15).
- `rx_rtr`  out  1  RTR bit of the last valid frame.
- `rx_valid`  out  1  one-cycle pulse: frame outputs updated.
- `rx_err`  out  1  one-cycle pulse: frame aborted.
- `err_code`  out  2  01 stuff, 10 CRC, 11 form; holds until next `rx_err`.
- `rxing`  out  1  high from SOF through CRC delimiter.

## Operation
- States: IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DEL, WAIT_IDLE. Transitions occur only on `baud_clk`.
- IDLE: a dominant sample is SOF. Go to ID with bit count 0, stuff run = 1 (value 0), and CRC cleared to 0. The SOF bit feeds the CRC.
- Destuffing applies from SOF through the last CRC bit.
  - After 5 consecutive equal bits, counting stuff bits, the next sample is a stuff bit.
  - Stuff bit opposite to the run: discard it, set run = 1 with that value, and leave the field counters unchanged.
  - Stuff bit equal to the run: stuff error.
- ID collects 11 bits, MSB first. Then RTR, IDE and R0 take 1 bit each. IDE = 1 is a form error. R0 is accepted at either value.
- DLC collects 4 bits. Data byte count = 0 if RTR = 1, otherwise min(DLC, 8).
- DATA collects 8 × byte count bits into a shadow register, MSB first from [63]. If the byte count is 0, skip directly to CRC.
- CRC over the destuffed bits from SOF to the last data bit:
  - Polynomial 0x4599, 15-bit.
  - Per bit: `crc = {crc[13:0],0} ^ ((bit ^ crc[14]) ? 15'h4599 : 0)`.
- CRC state collects 15 received bits without updating the computed CRC. Stuff rules still apply.
- CRC_DEL:
  - Dominant delimiter: form error.
  - Else if received CRC ≠ computed CRC: CRC error.
  - Else load `rx_id`, `rx_dlc`, `rx_rtr` and `rx_data` (shadow register, unused bytes zero), pulse `rx_valid`, and go to IDLE.
  - Stuff checking is off for the delimiter.
- ACK, EOF and intermission are not checked. IDLE treats any later dominant bit as SOF; upper logic gates on `rxing`.
- Any error:
  - Pulse `rx_err`, update `err_code`, drop `rxing`, and go to WAIT_IDLE.
  - Frame outputs are not modified.
  - WAIT_IDLE counts consecutive recessive samples; a dominant sample restarts the count. Reaching `IDLE_BITS` returns to IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, shadow register, counters and CRC all 0.
- Latency: `rx_valid` / `rx_err` are high for the `clk` cycle after the `clk` edge that samples the deciding bit with `baud_clk` = 1.
- Outputs update on the same edge as `rx_valid` rises.
- `rxing` rises on the edge sampling SOF and falls on the edge sampling CRC_DEL or an error bit.
- With `baud_clk` low, no state or counter changes.
- Back-to-back `baud_clk` strobes on every cycle must work.
- `rst` mid-frame: immediate return to reset values; the partial frame is discarded with no `rx_err`.
- Stuff error and end-of-field on the same bit: the stuff error wins.

## Test plan
- ID 0x123, DLC 2, data AA 55, correct CRC and stuffing, recessive delimiter -> one `rx_valid`; `rx_id` = 0x123, `rx_dlc` = 2, `rx_data` = 0xAA55000000000000, `rx_rtr` = 0.
- ID 0x000, DLC 0 (long dominant runs, stuff bits inserted) -> `rx_valid`; `rx_id` = 0, `rx_data` = 0. A missing stuff bit (6 dominant) instead gives `rx_err`, `err_code` = 01, `rxing` = 0.
- Valid frame with one CRC bit inverted (stuffing kept legal) -> `rx_err`, `err_code` = 10. Outputs keep the previous frame. The next frame is accepted only after 11 recessive bits.
- DLC = 12, data 01..08 -> `rx_dlc` = 12, `rx_data` = 0x0102030405060708. Separately, RTR = 1 with DLC = 4 -> no data field, `rx_data` = 0, `rx_rtr` = 1.
- IDE = 1 -> `err_code` = 11. Dominant CRC delimiter -> `err_code` = 11.
- Assert `rst` during the DATA field -> all outputs 0 and no pulses. A following clean frame decodes correctly. Also run `baud_clk` every cycle and every 16th cycle with the same results.
